picorv32_wb_master_bridge: RTL and testbench
============================================

// Module: picorv32_wb_master_bridge
// PURPOSE
//  Converts PicoRV32 native memory requests (mem_valid/mem_ready) into single Wishbone classic
//  read/write cycles; drives wbreg-style slaves directly downstream. One outstanding transfer.
//  Registered FSM; fixed 3-cycle request-to-ready latency with a 1-cycle-ack slave.
// PARAMETERS
//  TIMEOUT_CYCLES  255           BUS-state cycles without ack before forced termination (macro only)
//  ERR_RDATA       32'hBADC0DE0  mem_rdata returned on timeout
// PORTS
//  wb_clk_i    in   1   single clock, all logic posedge
//  arst_i      in   1   reset, asynchronous, active-high
//  mem_valid   in   1   core request valid
//  mem_instr   in   1   instruction fetch (unused; no effect on behaviour)
//  mem_ready   out  1   1-cycle completion pulse
//  mem_addr    in   32  byte address
//  mem_wdata   in   32  write data
//  mem_wstrb   in   4   byte strobes; 0 = read
//  mem_rdata   out  32  read data, valid while mem_ready=1
//  wbm_adr_o   out  32  WB address (mem_addr unmodified)
//  wbm_dat_o   out  32  WB write data
//  wbm_dat_i   in   32  WB read data
//  wbm_we_o    out  1   WB write enable
//  wbm_sel_o   out  4   WB byte select
//  wbm_stb_o   out  1   WB strobe
//  wbm_cyc_o   out  1   WB cycle
//  wbm_ack_i   in   1   WB acknowledge
//  timeout_o   out  1   sticky timeout flag (constant 0 without macro)
// BEHAVIOUR
//  - Reset (async, arst_i=1): state IDLE; every output incl. mem_rdata/wbm_* = 0.
//  - FSM IDLE/BUS. All outputs registered.
//  - IDLE: mem_valid=1 & mem_ready=0 -> latch adr=mem_addr, dat_o=mem_wdata, we=|mem_wstrb,
//    sel = we ? mem_wstrb : 4'hF; cyc=stb=1 next cycle; -> BUS. ack in IDLE ignored.
//  - BUS: hold adr/dat/we/sel/cyc/stb stable until ack. Edge sampling ack=1: cyc=stb=0,
//    mem_rdata = we ? 0 : wbm_dat_i, mem_ready=1 for exactly one cycle, -> IDLE.
//  - cyc/stb drop on the ack edge, so a toggling-ack slave never sees a 2nd strobe.
//  - Latency: mem_valid high cycle 0 -> cyc/stb cycle 1 -> ack cycle 2 -> mem_ready cycle 3.
//  - Back-to-back: new request accepted in the cycle after mem_ready (mem_ready=0 in IDLE).
//  - mem_valid dropping in BUS (core violation): WB cycle still completes; mem_ready still pulsed.
//  - Reset mid-BUS: cyc/stb drop asynchronously; no mem_ready; transfer lost.
// CONFIGURATION
//  WB_TIMEOUT_EN defined: counter clears on BUS entry and increments each BUS cycle without ack.
//   At count == TIMEOUT_CYCLES-1 with no ack: cyc=stb=0, mem_rdata=ERR_RDATA (reads and writes),
//   mem_ready pulsed, timeout_o=1 sticky until reset, -> IDLE.
//   Ack and timeout on the same edge: ack wins, normal completion, timeout_o unchanged.
//  WB_TIMEOUT_EN undefined: no counter; BUS waits for ack indefinitely; timeout_o tied 0.
// STRUCTURE
//  Package wb_bridge_pkg: FSM state encodings (ST_IDLE, ST_BUS), SEL_ALL=4'hF,
//   default ERR_RDATA constant.
//  Sub-module wb_timeout_ctr (clear, enable, terminal-count pulse), instantiated only under
//   WB_TIMEOUT_EN; width = $clog2(TIMEOUT_CYCLES).
// TESTING (bench pairs the bridge with a wbreg-style register slave, 1-cycle ack)
//  1 write 0x00 wdata=0xCAFEF00D wstrb=F -> we=1 sel=F; mem_ready cycle 3; readback = 0xCAFEF00D
//  2 read 0x04 after reg1 write 0x1234 -> sel=F we=0; mem_rdata=0x00001234 with mem_ready
//  3 two back-to-back reads 0x00,0x08 -> two separate cyc pulses, one stb per ack, 2 ready pulses
//  4 arst_i=1 during BUS -> cyc/stb/mem_ready=0 immediately; next request completes normally
//  5 WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack tied 0 -> cyc drops after 8 BUS cycles;
//    mem_rdata=0xBADC0DE0; timeout_o=1 and stays 1
//  6 no macro, ack tied 0 for 1000 cycles -> cyc/stb held, no mem_ready, timeout_o=0

Source files
------------

// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the PicoRV32-to-Wishbone master bridge: FSM encodings and bus constants.
package wb_bridge_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } bridge_state_e;

  localparam logic [3:0]  SEL_ALL           = 4'hF;
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hBADC0DE0;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog counter: clears on request, counts enabled cycles, flags the terminal count.
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // tc is only meaningful while enable is high, so an ack on the same edge suppresses it
  assign tc = enable && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/picorv32_wb_master_bridge.sv
// PicoRV32 native memory port to Wishbone classic master, one outstanding transfer.
// Optional bus watchdog enabled by defining WB_TIMEOUT_EN.
module picorv32_wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        wb_clk_i,
  input  logic        arst_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        timeout_o
);

  // Handshake: core request is taken when mem_valid=1 in IDLE with mem_ready=0; completion is a
  // single-cycle mem_ready pulse. WB side holds cyc/stb/adr/dat/we/sel until the edge sampling ack.
  bridge_state_e state_q;
  logic          accept;
  logic          tmo_tc;

  logic unused_instr;
  assign unused_instr = mem_instr;

  assign accept = (state_q == ST_IDLE) && mem_valid && !mem_ready;

`ifdef WB_TIMEOUT_EN
  wb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst    (arst_i),
    .clear  (accept),
    .enable ((state_q == ST_BUS) && !wbm_ack_i),
    .tc     (tmo_tc)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_RDATA, 32'(TIMEOUT_CYCLES)};
  assign tmo_tc     = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_stb_o <= 1'b0;
      wbm_cyc_o <= 1'b0;
`ifdef WB_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
    end else begin
      mem_ready <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            wbm_adr_o <= mem_addr;
            wbm_dat_o <= mem_wdata;
            wbm_we_o  <= |mem_wstrb;
            wbm_sel_o <= (|mem_wstrb) ? mem_wstrb : SEL_ALL;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state_q   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            mem_rdata <= wbm_we_o ? 32'h0 : wbm_dat_i;
            mem_ready <= 1'b1;
            state_q   <= ST_IDLE;
          end else if (tmo_tc) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            mem_rdata <= ERR_RDATA;
            mem_ready <= 1'b1;
`ifdef WB_TIMEOUT_EN
            timeout_o <= 1'b1;
`endif
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_wb_master_bridge.sv
// Bench for picorv32_wb_master_bridge with a 4-register, 1-cycle-ack Wishbone slave.
module tb_picorv32_wb_master_bridge;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif
  localparam logic [31:0] ERR_V = 32'hBADC0DE0;

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic        timeout_o;

  logic        ack_block = 1'b0;
  logic        ack_force = 1'b0;
  logic        slv_ack;
  logic [31:0] slv_regs [4];
  logic [31:0] shadow [4];

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc_rises = 0;
  int stb_acks = 0;
  logic cyc_d = 1'b0;

  always #5 clk = ~clk;

  picorv32_wb_master_bridge #(
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (ERR_V)
  ) dut (
    .wb_clk_i  (clk),
    .arst_i    (arst_i),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_ack_i (wbm_ack_i),
    .timeout_o (timeout_o)
  );

  // wbreg-style slave: registered ack, never acks two cycles in a row
  always @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      slv_ack   <= 1'b0;
      wbm_dat_i <= '0;
      for (int i = 0; i < 4; i++) slv_regs[i] <= '0;
    end else if (ack_block) begin
      slv_ack <= 1'b0;
    end else begin
      slv_ack <= wbm_cyc_o && wbm_stb_o && !slv_ack;
      if (wbm_cyc_o && wbm_stb_o && !slv_ack) begin
        wbm_dat_i <= slv_regs[wbm_adr_o[3:2]];
        if (wbm_we_o)
          for (int b = 0; b < 4; b++)
            if (wbm_sel_o[b]) slv_regs[wbm_adr_o[3:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
      end
    end
  end

  assign wbm_ack_i = slv_ack | ack_force;

  always @(posedge clk) begin
    cyc_d <= wbm_cyc_o;
    if (wbm_cyc_o && !cyc_d) cyc_rises <= cyc_rises + 1;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) stb_acks <= stb_acks + 1;
  end

  // Caller must be at a negedge; returns at the negedge where mem_ready was seen.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                      input int exp_lat, input logic exp_err, input string tag);
    logic [31:0] exp_v, got_v;
    logic        we_e;
    logic [3:0]  sel_e;
    int          lat;
    bit          bus_seen;
    we_e  = |wstrb;
    sel_e = we_e ? wstrb : 4'hF;
    if (exp_err)   exp_v = ERR_V;
    else if (we_e) exp_v = 32'h0;
    else           exp_v = shadow[addr[3:2]];
    exp_q.push_back(exp_v);
    if (we_e && !exp_err)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) shadow[addr[3:2]][8*b +: 8] = wdata[8*b +: 8];
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    lat = 0;
    bus_seen = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (wbm_cyc_o && !bus_seen) begin
        bus_seen = 1;
        n_cmp++;
        if ({wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_sel_o} !== {1'b1, addr, we_e, sel_e} ||
            (we_e && wbm_dat_o !== wdata)) begin
          n_err++;
          $display("FAIL %s bus: stb=%b adr=%h we=%b sel=%h dat=%h required stb=1 adr=%h we=%b sel=%h dat=%h",
                   tag, wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_dat_o, addr, we_e, sel_e, wdata);
        end
      end
      if (mem_ready) break;
    end
    mem_valid = 1'b0;
    mem_wstrb = '0;
    n_cmp++;
    if (!mem_ready) begin
      n_err++;
      $display("FAIL %s ready: no mem_ready within %0d cycles", tag, lat);
      void'(exp_q.pop_front());
      return;
    end
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    got_v = mem_rdata;
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s rdata: got %h required %h", tag, got_v, exp_v);
    end
  endtask

  task automatic test_reset();
    arst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_ready, mem_rdata, wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o, timeout_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b rdata=%h adr=%h dat=%h we=%b sel=%h stb=%b cyc=%b tmo=%b required all 0",
               mem_ready, mem_rdata, wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o, timeout_o);
    end
    arst_i = 1'b0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    xfer(32'h0, 32'hCAFEF00D, 4'hF, 3, 1'b0, "wr0");
    @(negedge clk);
    n_cmp++;
    if (mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_pulse_width: mem_ready=%b required 0", mem_ready);
    end
    xfer(32'h0, 32'h0, 4'h0, 3, 1'b0, "rd0");
    @(negedge clk);
    xfer(32'h4, 32'h00001234, 4'hF, 3, 1'b0, "wr1");
    @(negedge clk);
    xfer(32'h4, 32'h0, 4'h0, 3, 1'b0, "rd1");
    @(negedge clk);
  endtask

  task automatic test_byte_strobes();
    logic [31:0] d;
    logic [3:0]  s;
    xfer(32'hC, 32'hAABBCCDD, 4'b0101, 3, 1'b0, "wr3_part");
    @(negedge clk);
    xfer(32'hC, 32'h0, 4'h0, 3, 1'b0, "rd3_part");
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      xfer({28'h0, 2'($urandom_range(0, 3)), 2'b00}, d, s, 3, 1'b0, "rnd_wr");
      @(negedge clk);
      xfer({28'h0, 2'($urandom_range(0, 3)), 2'b00}, 32'h0, 4'h0, 3, 1'b0, "rnd_rd");
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int c0, a0;
    c0 = cyc_rises;
    a0 = stb_acks;
    xfer(32'h0, 32'h0, 4'h0, 3, 1'b0, "b2b_a");
    xfer(32'h8, 32'h0, 4'h0, 4, 1'b0, "b2b_b");
    @(negedge clk);
    n_cmp++;
    if (cyc_rises - c0 != 2 || stb_acks - a0 != 2) begin
      n_err++;
      $display("FAIL b2b_pulses: cyc_pulses=%0d acks=%0d required 2 and 2", cyc_rises - c0, stb_acks - a0);
    end
  endtask

  task automatic test_idle_ack();
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack: ready=%b cyc=%b required 0 0", mem_ready, wbm_cyc_o);
    end
  endtask

  task automatic test_valid_drop();
    int lat;
    exp_q.push_back(shadow[1]);
    mem_valid = 1'b1;
    mem_addr  = 32'h4;
    mem_wstrb = 4'h0;
    @(negedge clk);
    mem_valid = 1'b0;
    lat = 1;
    while (lat < 20 && !mem_ready) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (!mem_ready || lat != 3) begin
      n_err++;
      $display("FAIL valid_drop_ready: ready=%b latency=%0d required 1 and 3", mem_ready, lat);
      void'(exp_q.pop_front());
    end else begin
      n_cmp++;
      if (mem_rdata !== exp_q[0]) begin
        n_err++;
        $display("FAIL valid_drop_rdata: got %h required %h", mem_rdata, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus();
    mem_valid = 1'b1;
    mem_addr  = 32'h8;
    mem_wstrb = 4'h0;
    @(negedge clk);
    #2;
    arst_i    = 1'b1;
    mem_valid = 1'b0;
    #1;
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_bus: cyc=%b stb=%b ready=%b required 0 0 0", wbm_cyc_o, wbm_stb_o, mem_ready);
    end
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    @(negedge clk);
    arst_i = 1'b0;
    @(negedge clk);
    xfer(32'h8, 32'h5A5A0F0F, 4'hF, 3, 1'b0, "post_rst_wr");
    @(negedge clk);
    xfer(32'h8, 32'h0, 4'h0, 3, 1'b0, "post_rst_rd");
    @(negedge clk);
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    ack_block = 1'b1;
    xfer(32'h4, 32'h0, 4'h0, TMO + 1, 1'b1, "tmo_rd");
    n_cmp++;
    if (wbm_cyc_o !== 1'b0 || timeout_o !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_flag: cyc=%b timeout=%b required 0 1", wbm_cyc_o, timeout_o);
    end
    ack_block = 1'b0;
    @(negedge clk);
    xfer(32'h4, 32'h0, 4'h0, 3, 1'b0, "tmo_after_rd");
    @(negedge clk);
    n_cmp++;
    if (timeout_o !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_sticky: timeout=%b required 1", timeout_o);
    end
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    int lat;
    ack_block = 1'b1;
    exp_q.push_back(shadow[2]);
    mem_valid = 1'b1;
    mem_addr  = 32'h8;
    mem_wstrb = 4'h0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!(wbm_cyc_o && wbm_stb_o) || mem_ready) bad++;
    end
    n_cmp++;
    if (bad != 0 || timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL no_tmo_hold: bad_cycles=%0d timeout=%b required 0 0", bad, timeout_o);
    end
    ack_block = 1'b0;
    lat = 0;
    while (lat < 10 && !mem_ready) begin
      @(negedge clk);
      lat++;
    end
    mem_valid = 1'b0;
    n_cmp++;
    if (!mem_ready || mem_rdata !== exp_q[0]) begin
      n_err++;
      $display("FAIL no_tmo_release: ready=%b rdata=%h required 1 %h", mem_ready, mem_rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_byte_strobes();
    test_back_to_back();
    test_idle_ack();
    test_valid_drop();
    test_reset_mid_bus();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
